// File: rtl/minimizer_pkg.sv
// Shared constants, literal encodings and state type for the minimizer and its
// downstream cover checker.
package minimizer_pkg;

  localparam int MAX_VARS = 5;
  localparam int TERM_W   = 2 * MAX_VARS;
  localparam int FUNC_W   = 2 ** MAX_VARS;
  localparam int CNT_W    = 6;

  localparam logic [1:0] LIT_NEG = 2'b00;
  localparam logic [1:0] LIT_POS = 2'b01;
  localparam logic [1:0] LIT_DC  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Any pair with the upper bit set (2'b10 or 2'b11) means the variable is absent.
  function automatic logic lit_match(input logic [1:0] lit, input logic b);
    if (lit == LIT_NEG) begin
      return ~b;
    end else if (lit == LIT_POS) begin
      return b;
    end else begin
      return 1'b1;
    end
  endfunction

  function automatic int eff_vars(input logic [2:0] cap);
    return (cap > 3'd5) ? MAX_VARS : int'(cap);
  endfunction

  function automatic logic [0:FUNC_W-1] minterm_range(input logic [2:0] cap);
    logic [0:FUNC_W-1] r;
    r = '0;
    for (int k = 0; k < FUNC_W; k++) begin
      r[k] = (k < (1 << eff_vars(cap)));
    end
    return r;
  endfunction

endpackage

// File: rtl/implicant_expander.sv
// Combinational expansion of one implicant into the set of minterms it covers,
// restricted to the first 2**n minterms.
module implicant_expander
  import minimizer_pkg::*;
(
  input  logic [TERM_W-1:0] term,
  input  logic [2:0]        capacity,
  output logic [0:FUNC_W-1] mask
);

  int   n;
  logic hit;

  always_comb begin
    mask = '0;
    hit  = 1'b0;
    n    = eff_vars(capacity);
    for (int k = 0; k < FUNC_W; k++) begin
      hit = (k < (1 << n));
      // var j tests bit (n-1-j) of k, so var0 is the MSB of the minterm index
      for (int j = 0; j < MAX_VARS; j++) begin
        if (j < n) begin
          hit = hit & lit_match(term[TERM_W-1-2*j -: 2], 1'(k >> (n - 1 - j)));
        end else begin
          hit = hit;
        end
      end
      mask[k] = hit;
    end
  end

endmodule

// File: rtl/implicant_cover_checker.sv
// Accumulates the minimizer's implicant stream into a cover map and issues a
// one-cycle verdict comparing it against the latched truth table and term count.
module implicant_cover_checker
  import minimizer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [0:FUNC_W-1]   data,
  input  logic [2:0]          capacity,
  input  logic                ready_result,
  input  logic [TERM_W-1:0]   result,
  input  logic                result_end,
  input  logic [CNT_W-1:0]    res_count,
  output logic                check_done,
  output logic                check_ok,
  output logic                err_uncovered,
  output logic                err_overcover,
  output logic                err_count,
  output logic [CNT_W-1:0]    term_count,
  output logic [0:FUNC_W-1]   cover_map
);

  state_e              state_q, state_d;
  logic [0:FUNC_W-1]   func_q, func_d, cover_q, cover_d, mask;
  logic [2:0]          cap_q, cap_d;
  logic [CNT_W-1:0]    count_q, count_d, rc_q, rc_d;
  logic                done_q, done_d, ok_q, ok_d;
  logic                eu_q, eu_d, eo_q, eo_d, ec_q, ec_d;
  logic                relatch;

  implicant_expander u_expander (
    .term     (result),
    .capacity (cap_q),
    .mask     (mask)
  );

  // CHECK always advances to DONE, so a ready_result there is not honoured.
  assign relatch = ready_result && (state_q != ST_CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      cover_q <= '0;
      cap_q   <= 3'd0;
      count_q <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      cover_q <= cover_d;
      cap_q   <= cap_d;
      count_q <= count_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      eu_q    <= eu_d;
      eo_q    <= eo_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = relatch ? ST_ARMED : ST_IDLE;
      ST_ARMED:   state_d = relatch ? ST_ARMED : (result_end ? ST_CHECK : ST_COLLECT);
      ST_COLLECT: state_d = relatch ? ST_ARMED : (result_end ? ST_CHECK : ST_COLLECT);
      ST_CHECK:   state_d = ST_DONE;
      ST_DONE:    state_d = relatch ? ST_ARMED : ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    func_d  = func_q;
    cover_d = cover_q;
    cap_d   = cap_q;
    count_d = count_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    eu_d    = eu_q;
    eo_d    = eo_q;
    ec_d    = ec_q;
    if (relatch) begin
      func_d  = data & minterm_range(capacity);
      cap_d   = capacity;
      cover_d = '0;
      count_d = '0;
      rc_d    = '0;
      ok_d    = 1'b0;
      eu_d    = 1'b0;
      eo_d    = 1'b0;
      ec_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (result_end) rc_d = res_count;
          else            rc_d = rc_q;
        end
        ST_COLLECT: begin
          if (result_end) begin
            rc_d = res_count;
          end else begin
            cover_d = cover_q | mask;
            count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 6'd1;
          end
        end
        ST_CHECK: begin
          eu_d   = |(func_q & ~cover_q);
          eo_d   = |(cover_q & ~func_q);
          ec_d   = (count_q != rc_q);
          ok_d   = ~(eu_d | eo_d | ec_d);
          done_d = 1'b1;
        end
        default: done_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    check_done    = done_q;
    check_ok      = ok_q;
    err_uncovered = eu_q;
    err_overcover = eo_q;
    err_count     = ec_q;
    term_count    = count_q;
    cover_map     = cover_q;
  end

endmodule

// File: tb/tb_implicant_cover_checker.sv
// Directed and randomized streams checked against a set-based cover model.
module tb_implicant_cover_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] data;
  logic [2:0]  capacity;
  logic        ready_result;
  logic [9:0]  result;
  logic        result_end;
  logic [5:0]  res_count;
  logic        check_done, check_ok, err_uncovered, err_overcover, err_count;
  logic [5:0]  term_count;
  logic [0:31] cover_map;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] term_q[$];

  implicant_cover_checker dut (
    .clk(clk), .rst(rst), .data(data), .capacity(capacity),
    .ready_result(ready_result), .result(result), .result_end(result_end),
    .res_count(res_count), .check_done(check_done), .check_ok(check_ok),
    .err_uncovered(err_uncovered), .err_overcover(err_overcover),
    .err_count(err_count), .term_count(term_count), .cover_map(cover_map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Minterms matched by an implicant: k is covered iff it agrees with the
  // literal values on every cared-for variable.
  function automatic logic [0:31] term_mask(input logic [9:0] t, input int n);
    logic [0:31] m;
    logic [1:0]  p;
    int care, val;
    m = '0; care = 0; val = 0;
    for (int j = 0; j < n; j++) begin
      p = t[9-2*j -: 2];
      if (p[1] == 1'b0) begin
        care = care | (1 << (n - 1 - j));
        val  = val | (int'(p[0]) << (n - 1 - j));
      end
    end
    for (int k = 0; k < (1 << n); k++)
      if (((k ^ val) & care) == 0) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [0:31] cover_of(input int n);
    logic [0:31] c;
    c = '0;
    foreach (term_q[i]) c = c | term_mask(term_q[i], n);
    return c;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".done"}, 32'(check_done), 32'd0);
    chk({tag, ".ok"}, 32'(check_ok), 32'd0);
    chk({tag, ".eu"}, 32'(err_uncovered), 32'd0);
    chk({tag, ".eo"}, 32'(err_overcover), 32'd0);
    chk({tag, ".ec"}, 32'(err_count), 32'd0);
    chk({tag, ".tc"}, 32'(term_count), 32'd0);
    chk({tag, ".map"}, cover_map, 32'd0);
  endtask

  task automatic run_stream(input logic [0:31] d, input logic [2:0] cap,
                            input logic [5:0] rc, input string tag);
    logic [0:31] func, cov, fmask;
    logic eu, eo, ec, ok;
    int n, tc;
    n = int'(cap);
    fmask = '0;
    for (int k = 0; k < (1 << n); k++) fmask[k] = 1'b1;
    func = d & fmask;
    cov  = cover_of(n);
    tc   = (term_q.size() > 63) ? 63 : term_q.size();
    eu   = |(func & ~cov);
    eo   = |(cov & ~func);
    ec   = (tc != int'(rc));
    ok   = !(eu || eo || ec);

    @(negedge clk);
    ready_result = 1'b1; data = d; capacity = cap; result_end = 1'b0;
    @(negedge clk);
    ready_result = 1'b0;
    foreach (term_q[i]) begin
      @(negedge clk);
      result = term_q[i];
    end
    if (term_q.size() > 0) @(negedge clk);
    result_end = 1'b1; res_count = rc;
    @(negedge clk);
    result_end = 1'b0;
    chk({tag, ".done_early"}, 32'(check_done), 32'd0);
    @(negedge clk);
    chk({tag, ".done"}, 32'(check_done), 32'd1);
    chk({tag, ".ok"}, 32'(check_ok), 32'(ok));
    chk({tag, ".eu"}, 32'(err_uncovered), 32'(eu));
    chk({tag, ".eo"}, 32'(err_overcover), 32'(eo));
    chk({tag, ".ec"}, 32'(err_count), 32'(ec));
    chk({tag, ".tc"}, 32'(term_count), 32'(tc));
    chk({tag, ".map"}, cover_map, cov);
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(check_done), 32'd0);
    chk({tag, ".ok_hold"}, 32'(check_ok), 32'(ok));
    chk({tag, ".map_hold"}, cover_map, cov);
  endtask

  initial begin
    rst = 1'b1; data = '0; capacity = 3'd3; ready_result = 1'b0;
    result = '0; result_end = 1'b0; res_count = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    term_q = '{10'h0AA};
    run_stream(32'hF000_0000, 3'd3, 6'd1, "cap3_ok");
    term_q = '{10'h2AA};
    run_stream(32'hF000_0000, 3'd3, 6'd1, "cap3_over");
    term_q = '{10'h002};
    run_stream(32'h8001_0000, 3'd4, 6'd1, "cap4_uncov");
    term_q = '{10'h002, 10'h156};
    run_stream(32'h8001_0000, 3'd4, 6'd3, "cap4_count");
    term_q.delete();
    run_stream(32'h0000_0000, 3'd5, 6'd0, "empty");
    term_q.delete();
    for (int i = 0; i < 70; i++) term_q.push_back(10'h2AA);
    run_stream(32'hFF00_0000, 3'd3, 6'd63, "saturate");

    // Abort mid-collect, with result_end in the same cycle as ready_result.
    @(negedge clk); ready_result = 1'b1; data = 32'hFFFF_FFFF; capacity = 3'd5;
    @(negedge clk); ready_result = 1'b0;
    @(negedge clk); result = 10'h000;
    @(negedge clk); result = 10'h155;
    @(negedge clk); ready_result = 1'b1; result_end = 1'b1; res_count = 6'd2;
    @(negedge clk); ready_result = 1'b0; result_end = 1'b0;
    chk("abort.done", 32'(check_done), 32'd0);
    chk("abort.tc", 32'(term_count), 32'd0);
    term_q = '{10'h0AA};
    run_stream(32'hF000_0000, 3'd3, 6'd1, "after_abort");

    // Reset while collecting clears everything immediately.
    @(negedge clk); ready_result = 1'b1; data = 32'hFFFF_FFFF; capacity = 3'd5;
    @(negedge clk); ready_result = 1'b0;
    @(negedge clk); result = 10'h2AA;
    @(negedge clk); result = 10'h000;
    @(negedge clk);
    chk("pre_rst.tc", 32'(term_count), 32'd2);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("post_rst");
    term_q = '{10'h2AA};
    run_stream(32'hFF00_0000, 3'd3, 6'd1, "after_rst");

    for (int r = 0; r < 40; r++) begin
      logic [2:0]  cap;
      logic [0:31] d;
      logic [5:0]  rc;
      int nt;
      cap = 3'(3 + $urandom_range(0, 2));
      nt  = $urandom_range(0, 6);
      term_q.delete();
      for (int i = 0; i < nt; i++) term_q.push_back(10'($urandom));
      d  = ($urandom_range(0, 1) == 0) ? cover_of(int'(cap)) : 32'($urandom);
      rc = ($urandom_range(0, 3) != 0) ? 6'(nt) : 6'($urandom);
      run_stream(d, cap, rc, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
